div_sched: RTL and testbench

- Multicycle divide sequencer for the execute stage of the 5-stage MIPS pipeline.
- Accepts a DIV/DIVU issued in E (divE, hassignE from the main controller) and runs a radix-2 restoring shift-subtract divider, one bit per cycle.
- Holds the pipeline via stall_divE until the quotient/remainder pair is ready, then presents it for the HI/LO write.
- Supports cancellation by pipeline flush.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sched_if.sv | 29 ++
 rtl/div_step.sv | 23 ++
 rtl/div_sched.sv | 93 +++++++++
 tb/tb_div_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divide sequencer.
package div_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;

   // Quotient reported for a divide by zero.
   localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_sched_if.sv
// Execute-stage divide handshake: start/cancel request, operands, stall/valid and HI/LO results.
interface div_sched_if
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_W
);
   logic              divE;
   logic              hassignE;
   logic              cancelE;
   logic [DATA_W-1:0] srcaE;
   logic [DATA_W-1:0] srcbE;
   logic              stall_divE;
   logic              div_validE;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;
   logic              busy;

   // Pipeline side: issues the divide and watches the stall/result.
   modport master (
      output divE, hassignE, cancelE, srcaE, srcbE,
      input  stall_divE, div_validE, hi_o, lo_o, busy
   );

   // Divider side.
   modport slave (
      input  divE, hassignE, cancelE, srcaE, srcbE,
      output stall_divE, div_validE, hi_o, lo_o, busy
   );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);
   logic [W:0] trial;
   logic [W:0] diff;
   logic       fits;

   // The trial value needs one extra bit; the difference's top bit is clear exactly when trial >= divisor.
   always_comb begin
      trial    = {rem, quo[W-1]};
      diff     = trial - {1'b0, divisor};
      fits     = ~diff[W];
      rem_next = fits ? diff[W-1:0] : trial[W-1:0];
      quo_next = {quo[W-2:0], fits};
   end
endmodule

// File: rtl/div_sched.sv
// Multicycle DIV/DIVU sequencer for the execute stage: stalls E until quotient/remainder are ready.
module div_sched
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_W,
   parameter int CNT_W  = 5
) (
   input logic        clk,
   input logic        rst,
   div_sched_if.slave bus
);
   div_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, quo, dvsr;
   logic              qsign, rsign;
   logic [DATA_W-1:0] hi_r, lo_r;
   logic [DATA_W-1:0] rem_next, quo_next;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic              start;

   div_step #(.W(DATA_W)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvsr),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Start decode and operand magnitudes; start is gated by reset so no stall is seen while held in reset.
   always_comb begin
      start = rst & (state == DIV_IDLE) & bus.divE & ~bus.cancelE;
      a_abs = (bus.hassignE && bus.srcaE[DATA_W-1]) ? -bus.srcaE : bus.srcaE;
      b_abs = (bus.hassignE && bus.srcbE[DATA_W-1]) ? -bus.srcbE : bus.srcbE;
   end

   assign bus.stall_divE = start | (state == DIV_BUSY);
   assign bus.div_validE = (state == DIV_DONE) & ~bus.cancelE;
   assign bus.busy       = (state != DIV_IDLE);
   assign bus.hi_o       = hi_r;
   assign bus.lo_o       = lo_r;

   // Sequencer FSM with iteration counter, operand/sign registers and sign-corrected result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvsr  <= '0;
         qsign <= 1'b0;
         rsign <= 1'b0;
         hi_r  <= '0;
         lo_r  <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  qsign <= bus.hassignE & (bus.srcaE[DATA_W-1] ^ bus.srcbE[DATA_W-1]);
                  rsign <= bus.hassignE & bus.srcaE[DATA_W-1];
                  rem   <= '0;
                  cnt   <= '0;
                  quo   <= a_abs;
                  dvsr  <= b_abs;
                  if (bus.srcbE == '0) begin
                     hi_r  <= bus.srcaE;
                     lo_r  <= DIV_ZERO_Q;
                     state <= DIV_DONE;
                  end else begin
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (bus.cancelE) begin
                  state <= DIV_IDLE;
               end else begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + 1'b1;
                  // Results are taken straight from the final iteration so they land with the DONE transition.
                  if (cnt == CNT_W'(DATA_W - 1)) begin
                     hi_r  <= rsign ? -rem_next : rem_next;
                     lo_r  <= qsign ? -quo_next : quo_next;
                     state <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched: vector table plus cancel/back-to-back/reset sequences.
module tb_div_sched;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   div_sched_if #(.DATA_W(32)) bus ();

   div_sched #(.DATA_W(32), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] lo;
      logic [31:0] hi;
      int          cyc;
   } vec_t;

   vec_t vecs [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   // Issue one divide at the next negedge, hold divE while stalled, scramble operands after
   // the start cycle, and return results at the cycle div_validE is seen (bounded).
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output int vcyc, output int stalls);
      @(negedge clk);
      bus.divE     = 1'b1;
      bus.cancelE  = 1'b0;
      bus.srcaE    = a;
      bus.srcbE    = b;
      bus.hassignE = s;
      vcyc   = -1;
      stalls = 0;
      lo     = 'x;
      hi     = 'x;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.stall_divE === 1'b1) stalls++;
         if (bus.div_validE === 1'b1) begin
            vcyc = c;
            lo   = bus.lo_o;
            hi   = bus.hi_o;
            break;
         end
         @(negedge clk);
         bus.srcaE    = ~a;
         bus.srcbE    = b + 32'd3;
         bus.hassignE = ~s;
      end
   endtask

   initial begin
      logic [31:0] lo, hi;
      int          vcyc, stalls, vcount;
      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
      vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33};
      vecs[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33};
      vecs[3] = '{32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234,   1};
      vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33};
      vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   33};
      vecs[6] = '{32'hFFFFFFFF,   32'h10,         1'b0, 32'h0FFFFFFF,   32'hF,          33};
      vecs[7] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   33};
      vecs[8] = '{32'hFFFFFFF0,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF0,   1};
      vecs[9] = '{32'd50,         32'd5,          1'b0, 32'd10,         32'd0,          33};

      // Reset state
      rst          = 1'b0;
      bus.divE     = 1'b0;
      bus.hassignE = 1'b0;
      bus.cancelE  = 1'b0;
      bus.srcaE    = '0;
      bus.srcbE    = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", {31'd0, bus.stall_divE}, 32'd0);
      chk("reset_valid", {31'd0, bus.div_validE}, 32'd0);
      chk("reset_busy",  {31'd0, bus.busy}, 32'd0);
      chk("reset_hi",    bus.hi_o, 32'd0);
      chk("reset_lo",    bus.lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].a, vecs[i].b, vecs[i].s, lo, hi, vcyc, stalls);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("vec%0d_valid_cycle", i), vcyc, vecs[i].cyc);
         chk($sformatf("vec%0d_stall_cycles", i), stalls, vecs[i].cyc);
         @(negedge clk);
         bus.divE = 1'b0;
         #1;
         chk($sformatf("vec%0d_after_valid", i), {31'd0, bus.div_validE}, 32'd0);
         chk($sformatf("vec%0d_after_busy", i), {31'd0, bus.busy}, 32'd0);
      end

      // Cancel mid-operation: previous results 100/7 must survive
      run_div(32'd100, 32'd7, 1'b0, lo, hi, vcyc, stalls);
      @(negedge clk);
      bus.divE = 1'b0;
      @(negedge clk);
      bus.divE     = 1'b1;
      bus.srcaE    = 32'd1000;
      bus.srcbE    = 32'd3;
      bus.hassignE = 1'b0;
      #1;
      chk("cancel_start_stall", {31'd0, bus.stall_divE}, 32'd1);
      for (int c = 1; c <= 10; c++) @(negedge clk);
      bus.cancelE = 1'b1;
      @(negedge clk);
      bus.cancelE = 1'b0;
      bus.divE    = 1'b0;
      #1;
      chk("cancel_stall", {31'd0, bus.stall_divE}, 32'd0);
      chk("cancel_busy",  {31'd0, bus.busy}, 32'd0);
      chk("cancel_valid", {31'd0, bus.div_validE}, 32'd0);
      chk("cancel_lo",    bus.lo_o, 32'd14);
      chk("cancel_hi",    bus.hi_o, 32'd2);
      vcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (bus.div_validE === 1'b1) vcount++;
      end
      chk("cancel_no_pulse", vcount, 0);

      // Cancel in the start cycle
      @(negedge clk);
      bus.divE    = 1'b1;
      bus.cancelE = 1'b1;
      #1;
      chk("cancel_at_start_stall", {31'd0, bus.stall_divE}, 32'd0);
      @(negedge clk);
      bus.divE    = 1'b0;
      bus.cancelE = 1'b0;
      #1;
      chk("cancel_at_start_busy", {31'd0, bus.busy}, 32'd0);

      // Back-to-back: second divE lands in the cycle right after DONE
      run_div(32'd100, 32'd7, 1'b0, lo, hi, vcyc, stalls);
      chk("b2b_first_lo", lo, 32'd14);
      chk("b2b_first_stalls", stalls, 33);
      run_div(32'd50, 32'd5, 1'b0, lo, hi, vcyc, stalls);
      chk("b2b_second_lo", lo, 32'd10);
      chk("b2b_second_hi", hi, 32'd0);
      chk("b2b_second_valid_cycle", vcyc, 33);
      chk("b2b_second_stalls", stalls, 33);
      @(negedge clk);
      bus.divE = 1'b0;

      // Reset mid-operation
      @(negedge clk);
      bus.divE     = 1'b1;
      bus.srcaE    = 32'd100;
      bus.srcbE    = 32'd7;
      bus.hassignE = 1'b0;
      for (int c = 1; c <= 15; c++) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_stall", {31'd0, bus.stall_divE}, 32'd0);
      chk("rst_mid_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_valid", {31'd0, bus.div_validE}, 32'd0);
      chk("rst_mid_hi",    bus.hi_o, 32'd0);
      chk("rst_mid_lo",    bus.lo_o, 32'd0);
      @(negedge clk);
      bus.divE = 1'b0;
      rst      = 1'b1;
      run_div(32'd123456, 32'd1000, 1'b0, lo, hi, vcyc, stalls);
      chk("after_rst_lo", lo, 32'd123);
      chk("after_rst_hi", hi, 32'd456);
      chk("after_rst_valid_cycle", vcyc, 33);
      @(negedge clk);
      bus.divE = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
